// File: rtl/muldiv_unit_if.sv
// Request/response bundle between decode/execute and the iterative
// RV32M multiply/divide unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            is_m;
    logic            is_d;
    logic [2:0]      funct3;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            flush;
    logic            fin;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output is_m, is_d, funct3, src1, src2, flush,
        input  fin, result, busy
    );

    modport slave (
        input  is_m, is_d, funct3, src1, src2, flush,
        output fin, result, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, single-cycle fin pulse.
// Optional MULDIV_FAST_MUL_EN: single-cycle array multiply resolved at accept.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input logic          clk,
    input logic          rstn,
    muldiv_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [5:0]        cnt;
    logic [XLEN-1:0]   result_r;
    logic              result_wr;
    logic [XLEN-1:0]   result_nxt;

    logic [2:0]        f3;
    logic [XLEN-1:0]   mcand;
    logic [2*XLEN-1:0] prod;
    logic              neg_p;
    logic [XLEN-1:0]   dvsr;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    logic              neg_q;
    logic              neg_r;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
        logic signed [XLEN-1:0] sv;
        sv = v;
        return (sgn && (sv < 0)) ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_if_w(input logic [2*XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    // Accept decode and operand sign handling on the raw request.
    logic            accept;
    logic            m1_sgn;
    logic            m2_sgn;
    logic            d_sgn;
    logic            s1_neg;
    logic            s2_neg;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] spec_res;
    logic [XLEN-1:0] src1_mag_m;
    logic [XLEN-1:0] src2_mag_m;
    logic            mneg;

    assign accept   = (state == IDLE) & (bus.is_m | bus.is_d) & ~bus.flush;
    assign m1_sgn   = (bus.funct3[1:0] == 2'b01) | (bus.funct3[1:0] == 2'b10);
    assign m2_sgn   = (bus.funct3[1:0] == 2'b01);
    assign d_sgn    = ~bus.funct3[0];
    assign s1_neg   = bus.src1[XLEN-1];
    assign s2_neg   = bus.src2[XLEN-1];
    assign div_zero = (bus.src2 == '0);
    assign div_ovf  = d_sgn & (bus.src1 == {1'b1, {(XLEN-1){1'b0}}}) & (bus.src2 == '1);

    assign src1_mag_m = mag(bus.src1, m1_sgn);
    assign src2_mag_m = mag(bus.src2, m2_sgn);
    assign mneg       = (m1_sgn & s1_neg) ^ (m2_sgn & s2_neg);

    // funct3[1] distinguishes REM/REMU from DIV/DIVU.
    always_comb begin
        spec_res = '0;
        if (div_zero)
            spec_res = bus.funct3[1] ? bus.src1 : '1;
        else if (div_ovf)
            spec_res = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]   fast_res;

    assign fast_prod = neg_if_w({{XLEN{1'b0}}, src1_mag_m} * {{XLEN{1'b0}}, src2_mag_m}, mneg);
    assign fast_res  = (bus.funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

    // One shift-add multiply step and one restoring-divide step.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_step;
    logic [2*XLEN-1:0] prod_fin;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN:0]     rshift;
    logic [XLEN:0]     diff;
    logic              ge;
    logic [XLEN-1:0]   rem_step;
    logic [XLEN-1:0]   quot_step;
    logic [XLEN-1:0]   div_res;
    logic              last;

    assign mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
    assign prod_step = {mul_sum, prod[XLEN-1:1]};
    assign prod_fin  = neg_if_w(prod_step, neg_p);
    assign mul_res   = (f3[1:0] == 2'b00) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];

    assign rshift    = {rem, quot[XLEN-1]};
    assign diff      = rshift - {1'b0, dvsr};
    assign ge        = ~diff[XLEN];
    assign rem_step  = ge ? diff[XLEN-1:0] : rshift[XLEN-1:0];
    assign quot_step = {quot[XLEN-2:0], ge};
    assign div_res   = f3[1] ? neg_if(rem_step, neg_r) : neg_if(quot_step, neg_q);

    assign last      = (cnt == 6'(XLEN-1));

    always_comb begin
        state_nxt  = state;
        result_wr  = 1'b0;
        result_nxt = result_r;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.is_d) begin
                        if (div_zero || div_ovf) begin
                            state_nxt  = DONE;
                            result_wr  = 1'b1;
                            result_nxt = spec_res;
                        end else begin
                            state_nxt = DIV;
                        end
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        state_nxt  = DONE;
                        result_wr  = 1'b1;
                        result_nxt = fast_res;
`else
                        state_nxt  = MUL;
`endif
                    end
                end
            end
            MUL: begin
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else if (last) begin
                    state_nxt  = DONE;
                    result_wr  = 1'b1;
                    result_nxt = mul_res;
                end
            end
            DIV: begin
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else if (last) begin
                    state_nxt  = DONE;
                    result_wr  = 1'b1;
                    result_nxt = div_res;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            result_r <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                cnt <= '0;
            else if ((state == MUL) || (state == DIV))
                cnt <= cnt + 6'd1;
            if (result_wr)
                result_r <= result_nxt;
        end
    end

    // Datapath registers carry no reset; they are always loaded at accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            f3    <= bus.funct3;
            mcand <= src1_mag_m;
            prod  <= {{XLEN{1'b0}}, src2_mag_m};
            neg_p <= mneg;
            dvsr  <= mag(bus.src2, d_sgn);
            quot  <= mag(bus.src1, d_sgn);
            rem   <= '0;
            neg_q <= d_sgn & (s1_neg ^ s2_neg);
            neg_r <= d_sgn & s1_neg;
        end else if (state == MUL) begin
            prod <= prod_step;
        end else if (state == DIV) begin
            rem  <= rem_step;
            quot <= quot_step;
        end
    end

    assign bus.fin    = (state == DONE);
    assign bus.busy   = (state != IDLE);
    assign bus.result = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_mis;

    muldiv_unit_if #(.XLEN(32)) bus();

    muldiv_unit #(.XLEN(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [63:0] p;
        logic [63:0]        u;
        logic               ovf;
        logic [31:0]        r;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        case (f)
            3'd0: begin p = longint'(sa) * longint'(sb); r = p[31:0]; end
            3'd1: begin p = longint'(sa) * longint'(sb); r = p[63:32]; end
            3'd2: begin p = longint'(sa) * longint'({32'b0, b}); r = p[63:32]; end
            3'd3: begin u = {32'b0, a} * {32'b0, b}; r = u[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic d, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!d) return MUL_LAT;
        if (b == 0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one request in cycle 0 and check fin latency, result and busy timing.
    task automatic do_op(input string tag, input logic m, input logic d, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat);
        int lat;
        @(posedge clk); #1;
        bus.is_m = m; bus.is_d = d; bus.funct3 = f; bus.src1 = a; bus.src2 = b;
        @(posedge clk); #1;
        bus.is_m = 1'b0; bus.is_d = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) chk({tag, "_busy1"}, 32'(bus.busy), 32'd1);
            if (bus.fin) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, bus.result, exp_res);
        @(negedge clk);
        chk({tag, "_busy_after"}, 32'(bus.busy | bus.fin), 32'd0);
    endtask

    int          nfin;
    int          first_fin;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic        m;
    logic        d;

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rstn  = 1'b0;
        bus.is_m = 1'b0; bus.is_d = 1'b0; bus.funct3 = '0;
        bus.src1 = '0; bus.src2 = '0; bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_fin", 32'(bus.fin), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        do_op("mul",    1, 0, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        do_op("mulh",   1, 0, 3'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, MUL_LAT);
        do_op("mulhu",  1, 0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        do_op("mulhsu", 1, 0, 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT);
        do_op("div",    0, 1, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        do_op("rem",    0, 1, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        do_op("divu",   0, 1, 3'd5, 32'd100, 32'd7, 32'd14, 33);
        do_op("remu",   0, 1, 3'd7, 32'd100, 32'd7, 32'd2, 33);
        do_op("div0",   0, 1, 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        do_op("rem0",   0, 1, 3'd6, 32'd5, 32'd0, 32'd5, 1);
        do_op("divovf", 0, 1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("removf", 0, 1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        do_op("both",   1, 1, 3'd5, 32'd100, 32'd7, 32'd14, 33);

        for (int i = 0; i < 24; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            d = f[2];
            m = ~f[2] | ($urandom_range(0, 1) == 1);
            do_op($sformatf("rnd%0d_f%0d", i, f), m, d, f, a, b, ref_op(f, a, b), ref_lat(d, f, a, b));
        end

        // is_m held high for 40 cycles: no restart while busy.
        @(posedge clk); #1;
        bus.is_m = 1'b1; bus.is_d = 1'b0; bus.funct3 = 3'd0; bus.src1 = 32'd3; bus.src2 = 32'd5;
        nfin = 0;
        first_fin = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus.fin) begin
                nfin++;
                if (first_fin == 0) first_fin = c;
            end
            if (c == 34) chk("hold_busy34", 32'(bus.busy), 32'd0);
            if (c == 35) chk("hold_busy35", 32'(bus.busy), 32'd1);
        end
        chk("hold_first_fin", first_fin, MUL_LAT);
`ifdef MULDIV_FAST_MUL_EN
        chk("hold_nfin", nfin, 20);
`else
        chk("hold_nfin", nfin, 1);
`endif
        chk("hold_res", bus.result, 32'd15);
        @(posedge clk); #1;
        bus.is_m = 1'b0;
        for (int c = 0; c < 50 && bus.busy; c++) @(posedge clk);
        #1;
        chk("hold_drain", 32'(bus.busy), 32'd0);

        // Flush in cycle 10 of a divide.
        do_op("pre_flush", 0, 1, 3'd5, 32'd100, 32'd7, 32'd14, 33);
        @(posedge clk); #1;
        bus.is_d = 1'b1; bus.funct3 = 3'd4; bus.src1 = 32'd1000; bus.src2 = 32'd3;
        @(posedge clk); #1;
        bus.is_d = 1'b0;
        nfin = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 10) bus.flush = 1'b1;
            if (c == 11) bus.flush = 1'b0;
            @(negedge clk);
            if (c == 10) chk("flush_busy10", 32'(bus.busy), 32'd1);
            if (c == 11) chk("flush_busy11", 32'(bus.busy), 32'd0);
            if (bus.fin) nfin++;
            @(posedge clk); #1;
        end
        chk("flush_nfin", nfin, 0);
        chk("flush_res", bus.result, 32'd14);

        // Flush together with a request in IDLE blocks the accept.
        bus.is_m = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'd0; bus.src1 = 32'd2; bus.src2 = 32'd2;
        @(posedge clk); #1;
        bus.is_m = 1'b0; bus.flush = 1'b0;
        nfin = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) chk("idle_flush_busy", 32'(bus.busy), 32'd0);
            if (bus.fin) nfin++;
            @(posedge clk); #1;
        end
        chk("idle_flush_nfin", nfin, 0);
        chk("idle_flush_res", bus.result, 32'd14);

        // Asynchronous reset in cycle 20 of a multiply.
        bus.is_m = 1'b1; bus.funct3 = 3'd0; bus.src1 = 32'd9; bus.src2 = 32'd9;
        @(posedge clk); #1;
        bus.is_m = 1'b0;
        for (int c = 1; c < 20; c++) begin
            @(posedge clk); #1;
        end
        rstn = 1'b0;
        #1;
        chk("arst_fin", 32'(bus.fin), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_result", bus.result, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        nfin = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.fin) nfin++;
        end
        chk("arst_nfin", nfin, 0);
        do_op("post_rst", 1, 0, 3'd0, 32'd6, 32'd7, 32'd42, MUL_LAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
